// File: rtl/team_06_voice_ctrl.sv
// Talk/listen floor controller: conditions four buttons, runs the LIST/TALK/HOLD
// noise-gated FSM and drives the volume/effect path enables.
module team_06_voice_ctrl #(
  parameter int unsigned AUD_W     = 8,
  parameter int unsigned N_EFFECTS = 5,
  parameter int unsigned EFF_W     = 3,
  parameter int unsigned NG_OPEN   = 64,
  parameter int unsigned NG_CLOSE  = 48,
  parameter int unsigned HOLD_CYC  = 1024,
  parameter int unsigned DB_CYC    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AUD_W-1:0] mic_aud,
  input  logic [AUD_W-1:0] spk_aud,
  input  logic             ptt_btn,
  input  logic             ng_btn,
  input  logic             eff_btn,
  input  logic             mute_btn,
  output logic [1:0]       state,
  output logic             vol_en,
  output logic             eff_en,
  output logic [EFF_W-1:0] current_effect,
  output logic             mute_tog,
  output logic             ng_tog
);

  localparam int unsigned DB_W = $clog2(DB_CYC + 1);
  localparam int unsigned HC_W = $clog2(HOLD_CYC + 1);

  localparam int unsigned BtnPtt  = 0;
  localparam int unsigned BtnNg   = 1;
  localparam int unsigned BtnEff  = 2;
  localparam int unsigned BtnMute = 3;

  typedef enum logic [1:0] {
    StList = 2'b00,
    StTalk = 2'b01,
    StHold = 2'b10
  } state_e;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [3:0]           btn_raw;
  logic [3:0]           sync1_q, sync2_q;
  logic [3:0]           db_q, db_d;
  logic [3:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [3:1]           press_q, press_d;

  assign btn_raw = {mute_btn, eff_btn, ng_btn, ptt_btn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_cnt_q <= '0;
      press_q  <= '0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // Count only while the synced level disagrees; any agreement restarts the count.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DB_CYC - 1)) begin
          db_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    press_d = '0;
    for (int i = 1; i < 4; i++) begin
      press_d[i] = sync2_q[i] && !db_q[i] && (db_cnt_q[i] == DB_W'(DB_CYC - 1));
    end
  end

  logic ptt, ng_press, eff_press, mute_press;

  assign ptt        = db_q[BtnPtt];
  assign ng_press   = press_q[BtnNg];
  assign eff_press  = press_q[BtnEff];
  assign mute_press = press_q[BtnMute];

  // ---------------------------------------------------------------------------
  // Toggles and effect selector
  // ---------------------------------------------------------------------------
  logic             mute_q, mute_d;
  logic             ng_q, ng_d;
  logic [EFF_W-1:0] effect_q, effect_d;

  always_comb begin
    mute_d = mute_q ^ mute_press;
    ng_d   = ng_q ^ ng_press;
    if (32'(effect_q) >= N_EFFECTS) begin
      effect_d = '0;
    end else if (eff_press) begin
      effect_d = (32'(effect_q) == N_EFFECTS - 1) ? '0 : effect_q + EFF_W'(1);
    end else begin
      effect_d = effect_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mute_q   <= 1'b0;
      ng_q     <= 1'b0;
      effect_q <= '0;
    end else begin
      mute_q   <= mute_d;
      ng_q     <= ng_d;
      effect_q <= effect_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Floor-control FSM
  // ---------------------------------------------------------------------------
  logic gate_open, gate_close, spk;

  assign gate_open  = 32'(mic_aud) >= NG_OPEN;
  assign gate_close = 32'(mic_aud) < NG_CLOSE;
  assign spk        = spk_aud != '0;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;
  logic            hold_last;
  logic            vol_en_q, vol_en_d;
  logic            eff_en_q, eff_en_d;

  assign hold_last = hold_cnt_q == HC_W'(HOLD_CYC - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StList;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Decisions use the pre-edge ng toggle, so a same-cycle ng press acts next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StList: begin
        if (spk)                    state_d = StList;
        else if (ptt)               state_d = StTalk;
        else if (ng_q && gate_open) state_d = StTalk;
      end
      StTalk: begin
        if (ptt)             state_d = StTalk;
        else if (spk)        state_d = StList;
        else if (!ng_q)      state_d = StList;
        else if (gate_close) state_d = StHold;
      end
      StHold: begin
        if (ptt)            state_d = StTalk;
        else if (spk)       state_d = StList;
        else if (!ng_q)     state_d = StList;
        else if (gate_open) state_d = StTalk;
        else if (hold_last) state_d = StList;
      end
      default: state_d = StList;
    endcase
  end

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_d == StHold && state_q != StHold) begin
      hold_cnt_d = '0;
    end else if (state_q == StHold && !hold_last) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Enables decode from next-state values so they move on the same edge as state.
  always_comb begin
    vol_en_d = (state_d == StList) && !mute_d;
    eff_en_d = (state_d != StList) && (effect_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vol_en_q <= 1'b0;
      eff_en_q <= 1'b0;
    end else begin
      vol_en_q <= vol_en_d;
      eff_en_q <= eff_en_d;
    end
  end

  assign state          = state_q;
  assign vol_en         = vol_en_q;
  assign eff_en         = eff_en_q;
  assign current_effect = effect_q;
  assign mute_tog       = mute_q;
  assign ng_tog         = ng_q;

endmodule

// File: tb/tb_team_06_voice_ctrl.sv
// Directed bench for team_06_voice_ctrl: button conditioning, gate FSM, effects,
// mute and asynchronous reset.
module tb_team_06_voice_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 1024;
  localparam logic [1:0] LIST = 2'b00, TALK = 2'b01, HOLDS = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mic_aud, spk_aud;
  logic       ptt_btn, ng_btn, eff_btn, mute_btn;
  logic [1:0] state;
  logic       vol_en, eff_en, mute_tog, ng_tog;
  logic [2:0] current_effect;

  int checks   = 0;
  int failures = 0;

  team_06_voice_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .mic_aud        (mic_aud),
    .spk_aud        (spk_aud),
    .ptt_btn        (ptt_btn),
    .ng_btn         (ng_btn),
    .eff_btn        (eff_btn),
    .mute_btn       (mute_btn),
    .state          (state),
    .vol_en         (vol_en),
    .eff_en         (eff_en),
    .current_effect (current_effect),
    .mute_tog       (mute_tog),
    .ng_tog         (ng_tog)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mic;
    logic [7:0] spk;
    int         cycles;
    logic [1:0] st;
    logic       vol;
    logic       eff;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      0: ptt_btn  = v;
      1: ng_btn   = v;
      2: eff_btn  = v;
      default: mute_btn = v;
    endcase
  endtask

  // Effect lands on edge DB+3 after the rise; release then settles fully.
  task automatic press(input int which);
    set_btn(which, 1'b1);
    repeat (DB + 3) tick();
    set_btn(which, 1'b0);
    repeat (DB + 4) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 0);
    check({tag, "_vol"}, 32'(vol_en), 0);
    check({tag, "_effen"}, 32'(eff_en), 0);
    check({tag, "_effect"}, 32'(current_effect), 0);
    check({tag, "_mute"}, 32'(mute_tog), 0);
    check({tag, "_ng"}, 32'(ng_tog), 0);
  endtask

  initial begin
    vecs[0]  = '{8'd50, 8'd0, 1,        LIST,  1'b1, 1'b0};
    vecs[1]  = '{8'd63, 8'd0, 1,        LIST,  1'b1, 1'b0};
    vecs[2]  = '{8'd64, 8'd0, 1,        TALK,  1'b0, 1'b0};
    vecs[3]  = '{8'd50, 8'd0, 5,        TALK,  1'b0, 1'b0};
    vecs[4]  = '{8'd48, 8'd0, 1,        TALK,  1'b0, 1'b0};
    vecs[5]  = '{8'd47, 8'd0, 1,        HOLDS, 1'b0, 1'b0};
    vecs[6]  = '{8'd0,  8'd0, HOLD - 1, HOLDS, 1'b0, 1'b0};
    vecs[7]  = '{8'd0,  8'd0, 1,        LIST,  1'b1, 1'b0};
    vecs[8]  = '{8'd64, 8'd0, 1,        TALK,  1'b0, 1'b0};
    vecs[9]  = '{8'd0,  8'd0, 1,        HOLDS, 1'b0, 1'b0};
    vecs[10] = '{8'd50, 8'd0, 500,      HOLDS, 1'b0, 1'b0};
    vecs[11] = '{8'd70, 8'd0, 1,        TALK,  1'b0, 1'b0};
    vecs[12] = '{8'd0,  8'd0, 1,        HOLDS, 1'b0, 1'b0};
    vecs[13] = '{8'd0,  8'd0, HOLD - 1, HOLDS, 1'b0, 1'b0};
    vecs[14] = '{8'd0,  8'd0, 1,        LIST,  1'b1, 1'b0};
    vecs[15] = '{8'd70, 8'd5, 3,        LIST,  1'b1, 1'b0};
    vecs[16] = '{8'd70, 8'd0, 1,        TALK,  1'b0, 1'b0};
    vecs[17] = '{8'd70, 8'd5, 1,        LIST,  1'b1, 1'b0};
    vecs[18] = '{8'd64, 8'd0, 1,        TALK,  1'b0, 1'b0};
    vecs[19] = '{8'd0,  8'd0, 1,        HOLDS, 1'b0, 1'b0};
    vecs[20] = '{8'd0,  8'd5, 1,        LIST,  1'b1, 1'b0};
    vecs[21] = '{8'd0,  8'd0, 2,        LIST,  1'b1, 1'b0};

    rst = 1'b1;
    mic_aud = '0; spk_aud = '0;
    ptt_btn = 1'b0; ng_btn = 1'b0; eff_btn = 1'b0; mute_btn = 1'b0;

    // Reset state, then vol_en one cycle after release.
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
    check("vol_after_release", 32'(vol_en), 1);
    check("state_after_release", 32'(state), LIST);

    // PTT glitch shorter than the debounce window is ignored.
    ptt_btn = 1'b1;
    repeat (DB - 1) tick();
    ptt_btn = 1'b0;
    repeat (10) tick();
    check("ptt_glitch", 32'(state), LIST);

    // PTT latency: TALK on edge DB+3, not before.
    ptt_btn = 1'b1;
    repeat (DB + 2) tick();
    check("ptt_early", 32'(state), LIST);
    tick();
    check("ptt_talk", 32'(state), TALK);
    check("ptt_talk_vol", 32'(vol_en), 0);
    ptt_btn = 1'b0;
    repeat (DB + 2) tick();
    check("ptt_rel_early", 32'(state), TALK);
    tick();
    check("ptt_release", 32'(state), LIST);

    // Noise gate on, then gate / hang-timer / far-end vectors.
    press(1);
    check("ng_on", 32'(ng_tog), 1);
    for (int i = 0; i < NV; i++) begin
      mic_aud = vecs[i].mic;
      spk_aud = vecs[i].spk;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_vol", i), 32'(vol_en), 32'(vecs[i].vol));
      check($sformatf("vec%0d_effen", i), 32'(eff_en), 32'(vecs[i].eff));
    end

    // Effect cycling in LIST: eff_en stays low.
    for (int i = 1; i <= 6; i++) begin
      press(2);
      check($sformatf("eff_list%0d", i), 32'(current_effect), 32'(i % 5));
      check($sformatf("eff_list%0d_en", i), 32'(eff_en), 0);
    end
    mic_aud = 8'd64;
    tick();
    check("eff_talk_state", 32'(state), TALK);
    check("eff_talk_en", 32'(eff_en), 1);
    mic_aud = 8'd50;
    for (int i = 2; i <= 5; i++) begin
      press(2);
      check($sformatf("eff_talk%0d", i), 32'(current_effect), 32'(i % 5));
      check($sformatf("eff_talk%0d_en", i), 32'(eff_en), (i % 5) != 0 ? 1 : 0);
    end
    check("eff_talk_keep", 32'(state), TALK);
    mic_aud = 8'd0;
    tick();
    check("eff_hold", 32'(state), HOLDS);
    spk_aud = 8'd5;
    tick();
    check("eff_spk_list", 32'(state), LIST);
    spk_aud = 8'd0;

    // Talker keeps the floor over far end until PTT drops.
    ptt_btn = 1'b1;
    repeat (DB + 3) tick();
    check("ptt2_talk", 32'(state), TALK);
    spk_aud = 8'd5;
    repeat (3) tick();
    check("ptt_over_spk", 32'(state), TALK);
    ptt_btn = 1'b0;
    repeat (DB + 3) tick();
    check("ptt_drop_spk", 32'(state), LIST);
    spk_aud = 8'd0;
    tick();

    // Mute toggle.
    press(3);
    check("mute_on", 32'(mute_tog), 1);
    check("mute_on_vol", 32'(vol_en), 0);
    press(3);
    check("mute_off", 32'(mute_tog), 0);
    check("mute_off_vol", 32'(vol_en), 1);

    // Asynchronous reset mid-HOLD.
    press(2);
    check("pre_rst_effect", 32'(current_effect), 1);
    mic_aud = 8'd64;
    tick();
    mic_aud = 8'd0;
    tick();
    repeat (5) tick();
    check("pre_rst_hold", 32'(state), HOLDS);
    rst = 1'b1;
    #2;
    check_all_zero("midrst");
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_vol", 32'(vol_en), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
